// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide unit with HI/LO result registers.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
// Signed operations work on magnitudes and fix the result signs at the end.
// Handshake: start is accepted only when busy is low (IDLE); done pulses for
// one cycle after hi/lo are written by MULT/DIV, and a new start may be
// issued in that same cycle.
module muldiv_unit #(
    parameter int WIDTH = 32,
    parameter int OPW   = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [OPW-1:0] OP_MULT  = OPW'(0);
    localparam logic [OPW-1:0] OP_MULTU = OPW'(1);
    localparam logic [OPW-1:0] OP_DIV   = OPW'(2);
    localparam logic [OPW-1:0] OP_DIVU  = OPW'(3);
    localparam logic [OPW-1:0] OP_MTHI  = OPW'(4);
    localparam logic [OPW-1:0] OP_MTLO  = OPW'(5);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    // state is left visible for hierarchical observation
    state_t state;
    state_t state_nx;

    // latched operation context
    logic [WIDTH-1:0]   ma;        // multiplicand / dividend magnitude
    logic [WIDTH-1:0]   mb;        // multiplier / divisor magnitude
    logic [2*WIDTH-1:0] prod;      // mult: {acc, multiplier}; div: {rem, quotient}
    logic [CW-1:0]      cnt;
    logic               is_div_r;
    logic               neg_q;     // product / quotient is negative
    logic               neg_r;     // remainder is negative
    logic               dz;        // divisor was zero

    // decode and step datapath
    logic               is_md;
    logic               is_div;
    logic               sgn_op;
    logic               accept;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_sh;
    logic               div_ge;
    logic [WIDTH-1:0]   div_sub;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] p_fix;
    logic [WIDTH-1:0]   q_fix;
    logic [WIDTH-1:0]   r_fix;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    // op decode, operand magnitudes and one-bit step for multiply and divide
    always_comb begin
        is_md   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
        is_div  = (op == OP_DIV) || (op == OP_DIVU);
        sgn_op  = (op == OP_MULT) || (op == OP_DIV);
        accept  = (state == S_IDLE) && start && !flush && is_md;
        mag_a   = (sgn_op && a[WIDTH-1]) ? -a : a;
        mag_b   = (sgn_op && b[WIDTH-1]) ? -b : b;

        mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, ma} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, prod[WIDTH-1:1]};

        // shifted partial remainder always fits WIDTH+1 bits; the difference
        // is only kept when it is non-negative, so WIDTH bits suffice for it
        div_sh   = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        div_ge   = (div_sh >= {1'b0, mb});
        div_sub  = div_sh[WIDTH-1:0] - mb;
        div_next = {(div_ge ? div_sub : div_sh[WIDTH-1:0]), prod[WIDTH-2:0], div_ge};
    end

    // sign correction and final hi/lo selection
    always_comb begin
        p_fix  = neg_q ? -prod : prod;
        q_fix  = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        r_fix  = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
        fix_hi = is_div_r ? r_fix : p_fix[2*WIDTH-1:WIDTH];
        fix_lo = is_div_r ? (dz ? {WIDTH{1'b1}} : q_fix) : p_fix[WIDTH-1:0];
    end

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // next-state logic
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = S_CALC;
            S_CALC: begin
                if (flush)                         state_nx = S_IDLE;
                else if (cnt == CW'(WIDTH - 1))    state_nx = S_FIX;
            end
            S_FIX:   state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    // state-derived outputs
    always_comb begin
        busy = (state != S_IDLE);
    end

    // datapath: operand latch, iteration, result write-back and done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            ma       <= '0;
            mb       <= '0;
            prod     <= '0;
            cnt      <= '0;
            is_div_r <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        if (is_md) begin
                            ma       <= mag_a;
                            mb       <= mag_b;
                            cnt      <= '0;
                            is_div_r <= is_div;
                            neg_q    <= sgn_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_r    <= sgn_op && a[WIDTH-1];
                            dz       <= (b == '0);
                            prod     <= is_div ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
                        end else if (op == OP_MTHI) begin
                            hi <= a;
                        end else if (op == OP_MTLO) begin
                            lo <= a;
                        end
                    end
                end
                S_CALC: begin
                    if (!flush) begin
                        cnt  <= cnt + 1'b1;
                        prod <= is_div_r ? div_next : mul_next;
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        hi   <= fix_hi;
                        lo   <= fix_lo;
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
